data_sram_like_responder: RTL

- Responder (slave) end of the CPU's SRAM-like data interface: accepts requests via req/addr_ok, returns exactly one data_ok per accepted request, in order, after a configurable latency.
- Backs the interface with an internal word-addressed RAM.
- Used as the data-side memory model behind the MEM stage, and as the reference slave for stage-level benches.
- Read data is returned as a full aligned word; byte/half extraction stays in the MEM stage.

---
 rtl/data_sram_like_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/data_sram_like_responder.sv
// Responder end of the CPU's SRAM-like data interface, backed by an internal word RAM.
// Requests commit to the RAM when accepted; responses return in order after LATENCY cycles.
module data_sram_like_responder #(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        resp_stall
);

  localparam int PTR_W      = $clog2(MAX_OUTSTANDING);
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int LATENCY_M1 = LATENCY - 1;
  localparam logic [3:0]     CNT_INIT = LATENCY_M1[3:0];
  localparam logic [PTR_W:0] FULL_LVL = MAX_OUTSTANDING[PTR_W:0];

  logic [31:0]           mem    [DEPTH];
  logic                  q_wr   [MAX_OUTSTANDING];
  logic [31:0]           q_data [MAX_OUTSTANDING];
  logic [3:0]            q_cnt  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;
  logic                  resetn_q;
  logic                  accept;
  logic                  pop;
  logic                  head_ready;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_inputs;

  // Upper address bits alias onto the RAM; size is informational only.
  assign unused_inputs = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign idx           = addr[DEPTH_LOG2+1:2];

  // No bypass: a pop in this cycle does not free a slot until the next one.
  assign addr_ok    = resetn & resetn_q & (count < FULL_LVL);
  assign accept     = req & addr_ok;
  assign head_ready = (count != '0) && (q_cnt[rd_ptr] == 4'd0);
  assign data_ok    = resetn & head_ready & ~resp_stall;
  assign pop        = data_ok;
  assign rdata      = (data_ok && !q_wr[rd_ptr]) ? q_data[rd_ptr] : 32'b0;

  // Queue control: pointers, occupancy and per-entry latency countdown.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resetn_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        q_cnt[i] <= 4'd0;
      end
    end else begin
      resetn_q <= 1'b1;
      // Free slots always hold cnt=0, so counting down every slot is harmless.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (q_cnt[i] != 4'd0) begin
          q_cnt[i] <= q_cnt[i] - 4'd1;
        end
      end
      if (accept) begin
        q_cnt[wr_ptr] <= CNT_INIT;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Datapath: RAM update and load sampling at the accept edge (no reset on data).
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[wr_ptr]   <= wr;
      q_data[wr_ptr] <= wr ? 32'b0 : mem[idx];
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) begin
            mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
